// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues one fetch at a time to the memory
// controller, buffers returned words in a small FIFO and hands them to decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_o,
  output logic [31:0] if_addr_o,
  input  logic        if_busy_i,
  input  logic [31:0] if_addr_i,
  input  logic [31:0] if_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      addr_q, addr_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic             valid_q, valid_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      hpc_q, hpc_d;
  logic [31:0]      mem_inst_q [DEPTH];
  logic [31:0]      mem_pc_q   [DEPTH];

  logic             issue;
  logic             complete;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] remain;
  logic [31:0]      target;

  // A redirect cancels a same-cycle issue, and is gated out while reset is held.
  always_comb begin
    target   = branch_target_i & 32'hFFFF_FFFC;
    complete = (state_q == ST_WAIT) && !if_busy_i;
    issue    = rst && (state_q == ST_IDLE) && (count_q < DEPTH_C) && !branch_i;
    push     = complete && !drop_q && !branch_i;
    pop      = valid_q && id_ready_i && !branch_i;
  end

  always_comb begin
    if_o         = issue;
    if_addr_o    = issue ? pc_q : addr_q;
    inst_valid_o = valid_q;
    inst_o       = inst_q;
    pc_o         = hpc_q;
  end

  always_comb begin
    state_d = state_q;
    if (issue) begin
      state_d = ST_WAIT;
    end else if (complete) begin
      state_d = ST_IDLE;
    end

    pc_d   = branch_i ? target : (issue ? pc_q + 32'd4 : pc_q);
    addr_d = issue ? pc_q : addr_q;

    // The drop flag swallows the completion of a fetch that a redirect orphaned.
    drop_d = drop_q;
    if (complete) begin
      drop_d = 1'b0;
    end else if (branch_i && (state_q == ST_WAIT)) begin
      drop_d = 1'b1;
    end
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    hpc_d   = hpc_q;
    remain  = count_q - CNT_W'(pop);
    if (branch_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      valid_d = 1'b0;
    end else begin
      rd_d    = rd_q + PTR_W'(pop);
      wr_d    = wr_q + PTR_W'(push);
      count_d = remain + CNT_W'(push);
      valid_d = (count_d != '0);
      // Next head is either an entry already stored or the word arriving now.
      if (remain == '0) begin
        if (push) begin
          inst_d = if_data_i;
          hpc_d  = if_addr_i;
        end
      end else begin
        inst_d = mem_inst_q[rd_d];
        hpc_d  = mem_pc_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      drop_q  <= 1'b0;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      valid_q <= 1'b0;
      inst_q  <= '0;
      hpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      hpc_q   <= hpc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst_q[wr_q] <= if_data_i;
      mem_pc_q[wr_q]   <= if_addr_i;
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage sitting directly upstream of `mem_controller`'s instruction port. Holds the program counter and issues one 32-bit fetch request at a time over the controller's `if` handshake. Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake. Handles branch redirects by flushing buffered words and discarding any fetch already in flight.

## Interface
- `RESET_PC`, default 32'h0: PC value loaded on reset; must be 4-byte aligned.
- `DEPTH`, default 2: instruction FIFO entries; legal values are 2 or 4.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset; synchronous, active-low.
- `if_o` in-to-controller, out 1: fetch request, a one-cycle pulse.
- `if_addr_o` out 32: fetch address; valid in the `if_o` cycle, held until the next request.
- `if_busy_i` in 1: controller busy; the controller raises it in the request cycle.
- `if_addr_i` in 32: address of the completed word; valid in the completion cycle.
- `if_data_i` in 32: completed instruction word, little-endian; valid in the completion cycle.
- `inst_valid_o` out 1: FIFO head is valid.
- `inst_o` out 32: FIFO head instruction.
- `pc_o` out 32: FIFO head address.
- `id_ready_i` in 1: decode accepts the head.
- `branch_i` in 1: redirect request, one cycle.
- `branch_target_i` in 32: redirect target; bits [1:0] are ignored and treated as 0.

## Operation
- **State machine:**
  - IDLE: issue a request when `count + outstanding < DEPTH`.
    - Drive `if_o=1` and `if_addr_o=pc` for one cycle.
    - Advance `pc <= pc+4` (mod 2^32; 32'hFFFFFFFC wraps to 0).
    - Go to WAIT.
  - WAIT: completion is any cycle in WAIT with `if_busy_i==0`.
    - On completion, return to IDLE.
    - If the drop flag is clear, push {`if_addr_i`, `if_data_i`}.
- **FIFO:**
  - Circular buffer; `count` ranges 0..DEPTH.
  - Pop when `inst_valid_o && id_ready_i`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Push never occurs at full; the issue rule guarantees this.
- **Redirect (`branch_i=1`):** highest priority, overrides pop.
  - Flush the FIFO: `count=0`, pointers reset.
  - Set `pc <= {branch_target_i[31:2],2'b00}`.
  - If in WAIT and not completing this cycle, set drop flag.
  - If completing this cycle, discard that word; no flag is needed.
  - A redirect in the same cycle as an IDLE issue cancels the issue: `if_o=0`.
- **Drop flag:** cleared on the completion it discards. A second redirect while the flag is set only updates `pc`.
- Outstanding fetches are at most 1.

## Timing
- **Reset values:**
  - `if_o=0`, `if_addr_o=0`, `inst_valid_o=0`, `inst_o=0`, `pc_o=0`.
  - `pc=RESET_PC`, state IDLE, `count=0`, drop flag 0.
- First request occurs in the first cycle after `rst` is released.
- **Latency:** request cycle, then WAIT until completion. The word is visible on `inst_*` in the cycle after completion.
- **Back-to-back fetches:** the next request is issued in the cycle after completion; IDLE lasts 1 cycle.
- `inst_valid_o` and the head fields are registered outputs, stable while not popped.
- **Redirect visibility:**
  - `inst_valid_o=0` in the cycle after `branch_i`.
  - The first request to the target is issued in that cycle if IDLE.
  - Otherwise it is issued in the cycle after the dropped completion.
- **Reset mid-WAIT:** all state clears. The controller is reset by the same signal, so no completion is expected afterwards.

## Test plan
- **Sequential fetch:**
  - Stimulus: `RESET_PC=0`; controller model completes 8 cycles after each request; `id_ready_i=1`.
  - Required: `pc_o` sequence 0,4,8,C with matching `inst_o`; one `if_o` pulse per fetch.
- **Backpressure:**
  - Stimulus: `id_ready_i=0` with DEPTH=2.
  - Required: exactly 2 requests issued; `inst_o` holds word@0. Raising ready drains 0 then 4, then fetching resumes at 8.
- **Redirect mid-WAIT:**
  - Stimulus: `branch_i` with target 32'h100 while fetching 32'h8.
  - Required: word@8 never appears; the next `if_addr_o` is 32'h100, issued after the controller completes the fetch of 8.
- **Redirect coincident with completion:**
  - Stimulus: `branch_i` in the same cycle as the completion of 32'hC; target 32'h203.
  - Required: word@C is discarded; request to 32'h200 issued in the next cycle.
- **Wrap-around:**
  - Stimulus: redirect to 32'hFFFFFFFC.
  - Required: fetches FFFFFFFC, then 00000000.
- **Reset mid-operation:**
  - Stimulus: assert `rst=0` during WAIT with 1 word buffered.
  - Required: all outputs return to reset values in the next cycle; after release, the first request is to `RESET_PC`.
